csa_accum_sequencer: RTL and testbench

//  Sequencer for the carry-save datapath. Accepts a stream of XLEN-bit operands over valid/ready.

---
 rtl/csa_acc_pkg.sv | 16 +
 rtl/csa_accum_sequencer_csa.sv | 15 +
 rtl/csa_accum_sequencer.sv | 128 ++++++++++++
 tb/tb_csa_accum_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types for the carry-save accumulate sequencer: FSM state and guard-bit sizing.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Extra headroom bits so a full burst of XLEN-bit operands cannot overflow.
    function automatic int unsigned guard_bits(input int unsigned max_ops);
        return $clog2(max_ops) + 1;
    endfunction

endpackage

// File: rtl/csa_accum_sequencer_csa.sv
// 3:2 carry-save compressor; sum and majority carry per bit, no propagation.
module csa_accum_sequencer_csa #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/csa_accum_sequencer.sv
// Folds an operand burst into a redundant S/C pair, then resolves it with one add.
// Optional CSA_ACC_OVF_EN widens S/C with guard bits and adds the res_ovf_o output.
module csa_accum_sequencer
    import csa_acc_pkg::*;
#(
    parameter int XLEN    = 49,
    parameter int MAX_OPS = 16,
    parameter int CNTW    = $clog2(MAX_OPS + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic [XLEN-1:0] op_data_i,
    input  logic            op_last_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_data_o,
    output logic [CNTW-1:0] res_count_o,
`ifdef CSA_ACC_OVF_EN
    output logic            res_ovf_o,
`endif
    output logic            busy_o
);

`ifdef CSA_ACC_OVF_EN
    localparam int IW = XLEN + int'(guard_bits(MAX_OPS));
`else
    localparam int IW = XLEN;
`endif

    state_e          r_state;
    logic [IW-1:0]   r_s;
    logic [IW-1:0]   r_c;
    logic [CNTW-1:0] r_cnt;
    logic [XLEN-1:0] r_res_data;
    logic [CNTW-1:0] r_res_cnt;

    logic [IW-1:0]   w_op;
    logic [IW-1:0]   w_cb;
    logic [IW-1:0]   w_sum;
    logic [IW-1:0]   w_cy;
    logic [IW-1:0]   w_res;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            w_ready;
    logic            w_acc;
    logic            w_last;

`ifdef CSA_ACC_OVF_EN
    logic            r_ovf;
    assign w_op      = {{(IW - XLEN){1'b0}}, op_data_i};
    assign res_ovf_o = r_ovf;
`else
    assign w_op      = op_data_i;
`endif

    // Carry word is weighted by 2; its top bit falls off (mod 2^IW).
    assign w_cb = {r_c[IW-2:0], 1'b0};

    csa_accum_sequencer_csa #(.W(IW)) u_csa (
        .i_a     (r_s),
        .i_b     (w_cb),
        .i_c     (w_op),
        .o_sum   (w_sum),
        .o_carry (w_cy)
    );

    assign w_res     = r_s + w_cb;
    assign w_cnt_nxt = r_cnt + {{(CNTW - 1){1'b0}}, 1'b1};
    assign w_last    = op_last_i | (w_cnt_nxt == CNTW'(MAX_OPS));
    assign w_ready   = rst_ni & ~flush_i & ((r_state == IDLE) | (r_state == ACCUM));
    assign w_acc     = op_valid_i & w_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_c        <= '0;
            r_cnt      <= '0;
            r_res_data <= '0;
            r_res_cnt  <= '0;
`ifdef CSA_ACC_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else if (flush_i) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE, ACCUM: begin
                    if (w_acc) begin
                        r_s     <= w_sum;
                        r_c     <= w_cy;
                        r_cnt   <= w_cnt_nxt;
                        r_state <= w_last ? RESOLVE : ACCUM;
                    end
                end
                RESOLVE: begin
                    r_res_data <= w_res[XLEN-1:0];
                    r_res_cnt  <= r_cnt;
`ifdef CSA_ACC_OVF_EN
                    r_ovf      <= |w_res[IW-1:XLEN];
`endif
                    r_state    <= DONE;
                end
                DONE: begin
                    if (res_ready_i) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_ready_o  = w_ready;
    assign res_valid_o = (r_state == DONE);
    assign res_data_o  = r_res_data;
    assign res_count_o = r_res_cnt;
    assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Directed bench for csa_accum_sequencer with hand-computed expectations.
module tb_csa_accum_sequencer;

    localparam int XLEN = 49;
    localparam int CNTW = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            op_valid_i;
    logic            op_ready_o;
    logic [XLEN-1:0] op_data_i;
    logic            op_last_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] res_data_o;
    logic [CNTW-1:0] res_count_o;
    logic            busy_o;
`ifdef CSA_ACC_OVF_EN
    logic            res_ovf_o;
`endif

    int total = 0;
    int bad   = 0;

    csa_accum_sequencer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_data_i   (op_data_i),
        .op_last_i   (op_last_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_count_o (res_count_o),
`ifdef CSA_ACC_OVF_EN
        .res_ovf_o   (res_ovf_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [XLEN-1:0] d, input logic last);
        op_valid_i = 1'b1;
        op_data_i  = d;
        op_last_i  = last;
        #1;
        chk("send_ready", {63'd0, op_ready_o}, 64'd1);
        step();
        op_valid_i = 1'b0;
        op_last_i  = 1'b0;
    endtask

    task automatic handshake();
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        chk("hs_valid", {63'd0, res_valid_o}, 64'd0);
        chk("hs_busy", {63'd0, busy_o}, 64'd0);
        chk("hs_ready", {63'd0, op_ready_o}, 64'd1);
    endtask

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        op_valid_i  = 1'b0;
        op_data_i   = '0;
        op_last_i   = 1'b0;
        res_ready_i = 1'b0;
        step();
        step();
        chk("rst_ready", {63'd0, op_ready_o}, 64'd0);
        chk("rst_valid", {63'd0, res_valid_o}, 64'd0);
        chk("rst_data", {15'd0, res_data_o}, 64'd0);
        chk("rst_count", {59'd0, res_count_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        rst_ni = 1'b1;
        #1;
        chk("idle_ready", {63'd0, op_ready_o}, 64'd1);

        // Burst 3,5,7 with last on 7
        send(49'd3, 1'b0);
        chk("t1_busy", {63'd0, busy_o}, 64'd1);
        send(49'd5, 1'b0);
        send(49'd7, 1'b1);
        chk("t1_resolve_valid", {63'd0, res_valid_o}, 64'd0);
        chk("t1_resolve_ready", {63'd0, op_ready_o}, 64'd0);
        step();
        chk("t1_valid", {63'd0, res_valid_o}, 64'd1);
        chk("t1_data", {15'd0, res_data_o}, 64'd15);
        chk("t1_count", {59'd0, res_count_o}, 64'd3);
        handshake();

        // Sixteen copies of 2^48 without last: forced last, wraps to zero
        for (int i = 0; i < 16; i++) send(49'h1_0000_0000_0000, 1'b0);
        chk("t2_resolve_ready", {63'd0, op_ready_o}, 64'd0);
        step();
        chk("t2_valid", {63'd0, res_valid_o}, 64'd1);
        chk("t2_data", {15'd0, res_data_o}, 64'd0);
        chk("t2_count", {59'd0, res_count_o}, 64'd16);
`ifdef CSA_ACC_OVF_EN
        chk("t2_ovf", {63'd0, res_ovf_o}, 64'd1);
`endif
        handshake();

        // Single operand burst, then hold the result for five cycles
        send(49'h1_2345, 1'b1);
        step();
        chk("t3_data", {15'd0, res_data_o}, 64'h1_2345);
        chk("t3_count", {59'd0, res_count_o}, 64'd1);
        op_valid_i = 1'b1;
        op_data_i  = 49'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_valid", {63'd0, res_valid_o}, 64'd1);
            chk("t4_data", {15'd0, res_data_o}, 64'h1_2345);
            chk("t4_ready", {63'd0, op_ready_o}, 64'd0);
        end
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        op_valid_i  = 1'b0;
        chk("t4_idle_busy", {63'd0, busy_o}, 64'd0);
        chk("t4_idle_valid", {63'd0, res_valid_o}, 64'd0);
        chk("t4_idle_ready", {63'd0, op_ready_o}, 64'd1);

        // Flush mid-burst; the operand offered in the flush cycle is dropped
        send(49'd10, 1'b0);
        send(49'd20, 1'b0);
        flush_i    = 1'b1;
        op_valid_i = 1'b1;
        op_data_i  = 49'd100;
        #1;
        chk("t5_flush_ready", {63'd0, op_ready_o}, 64'd0);
        step();
        flush_i    = 1'b0;
        op_valid_i = 1'b0;
        chk("t5_flush_busy", {63'd0, busy_o}, 64'd0);
        chk("t5_flush_valid", {63'd0, res_valid_o}, 64'd0);
        send(49'd4, 1'b1);
        step();
        chk("t5_valid", {63'd0, res_valid_o}, 64'd1);
        chk("t5_data", {15'd0, res_data_o}, 64'd4);
        chk("t5_count", {59'd0, res_count_o}, 64'd1);

        // Reset while DONE
        rst_ni = 1'b0;
        step();
        chk("t6_valid", {63'd0, res_valid_o}, 64'd0);
        chk("t6_busy", {63'd0, busy_o}, 64'd0);
        chk("t6_data", {15'd0, res_data_o}, 64'd0);
        chk("t6_ready_in_rst", {63'd0, op_ready_o}, 64'd0);
        rst_ni = 1'b1;
        step();
        chk("t6_ready", {63'd0, op_ready_o}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
